easyaxi_slv_wr_ctrl: RTL
========================

// Module: easyaxi_slv_wr_ctrl
// PURPOSE
//  AXI write-slave controller, the responder for the EasyAXI master write path. Accepts AW into an
//  outstanding queue, consumes W beats in AW order, and generates per-beat addresses (FIXED/INCR/WRAP)
//  for a simple memory write port. Returns one in-order B per burst. Sits between the interconnect and
//  the slave memory model.
// PARAMETERS
//  OST_DEPTH  4  depth of the AW queue and of the B queue (power of 2, >=2)
// PORTS
//  clk              in   1                single clock, rising edge
//  rst              in   1                synchronous, active-high reset
//  axi_slv_awvalid  in   1                AW valid
//  axi_slv_awready  out  1                AW ready
//  axi_slv_awid/awaddr/awlen/awsize/awburst/awuser  in  `AXI_*_W  AW payload
//  axi_slv_wvalid   in   1                W valid
//  axi_slv_wready   out  1                W ready
//  axi_slv_wdata    in   `AXI_DATA_W      write data
//  axi_slv_wstrb    in   `AXI_DATA_W/8    byte strobes
//  axi_slv_wlast    in   1                last beat flag
//  axi_slv_bvalid   out  1                B valid
//  axi_slv_bready   in   1                B ready
//  axi_slv_bid      out  `AXI_ID_W        = awid of the burst
//  axi_slv_bresp    out  `AXI_RESP_W      OKAY or SLVERR
//  axi_slv_buser    out  `AXI_USER_W      = awuser of the burst
//  mem_wen          out  1                memory write strobe, 1 cycle per accepted legal beat
//  mem_waddr        out  `AXI_ADDR_W      beat address
//  mem_wdata/mem_wstrb  out  `AXI_DATA_W / `AXI_DATA_W/8  = wdata/wstrb of the beat
// BEHAVIOUR
//  Reset: queues empty, beat cnt=0, err flag=0; awready=1 one cycle after reset release, wready=0,
//   bvalid=0, mem_wen=0, bid/bresp/buser=0. A reset during a burst drops it: no B, no further mem writes.
//  AW queue: awready=~aw_full. Push on awvalid&awready. Entry = {id,addr,len,size,burst,user}.
//  W: wready = aw_not_empty & ~b_full. The AW queue is registered, so an AW accepted at cycle N enables
//   wready no earlier than N+1. W arriving before AW stalls (wready=0); this is legal AXI.
//  Beat handshake (wvalid&wready): mem_wen/waddr/wdata/wstrb are combinational from the head entry and
//   the current addr, in the same cycle. Beat cnt increments, width `AXI_LEN_W.
//  Addr gen, bytes=1<<size: FIXED addr held. INCR addr+=bytes. WRAP: lower boundary =
//   addr & ~((len+1)*bytes-1); next = addr+bytes, and it wraps to the lower boundary when it reaches
//   boundary+(len+1)*bytes. Addr arithmetic is `AXI_ADDR_W wide and wraps modulo 2^`AXI_ADDR_W.
//  Burst end: the beat with cnt==len. AWLEN is authoritative, so wlast never ends a burst early.
//   On burst end: pop the AW entry, push {id,resp,user} to the B queue, and clear cnt and the err flag.
//  SLVERR conditions:
//   - wlast != (cnt==len) on any beat. Writes still occur.
//   - size > log2(`AXI_DATA_W/8). mem_wen is suppressed for the whole burst.
//   - WRAP with len not in {1,3,7,15}. mem_wen is suppressed for the whole burst.
//   - burst type 2'b11 (reserved). mem_wen is suppressed for the whole burst.
//  B queue: bvalid = b_not_empty, outputs from head, pop on bvalid&bready. B can be valid the cycle
//   after the last-beat handshake at the earliest. Responses are strictly in AW order.
//  Simultaneous events: push+pop on the same queue in the same cycle is allowed, including when full
//   (full AW queue: awready=0 stays; a pop does not open awready in the same cycle). A last beat with
//   b_full cannot occur because wready=0 while b_full.
//  Up to OST_DEPTH bursts are accepted ahead of W data, and up to OST_DEPTH responses are held against
//   bready=0.
// TESTING
//  1 INCR len=3 size=2 addr=0x10, wdata 0..3, wlast on beat 3 -> mem_waddr 0x10,0x14,0x18,0x1C;
//    one B bid=awid, bresp=OKAY.
//  2 WRAP len=3 size=2 addr=0x34 -> mem_waddr 0x34,0x38,0x3C,0x30; FIXED addr=0x40 len=3 ->
//    0x40 x4; both OKAY.
//  3 Send 4 AWs (ids 0..3) with wvalid=0 -> 5th AW sees awready=0; then send W for all four ->
//    B order 0,1,2,3.
//  4 wlast on beat 1 of a len=3 burst -> 4 mem writes, bresp=SLVERR. size=3 on a 32-bit bus ->
//    mem_wen stays 0, SLVERR.
//  5 bready=0 for 4 bursts -> wready drops after the 4th burst end; bready=1 drains B, wready returns.
//  6 Assert rst mid-burst (beat 2 of 4) -> next cycle bvalid=0, wready=0, mem_wen=0; a new burst
//    after reset completes OKAY.

Source files
------------

// File: rtl/easyaxi_slv_wr_ctrl.sv
// easyaxi_slv_wr_ctrl
//   AXI write-slave controller. AW requests are queued (up to OST_DEPTH
//   outstanding), W beats are consumed in AW order and turned into per-beat
//   memory writes with FIXED/INCR/WRAP address generation, and one in-order
//   B response per burst is queued (up to OST_DEPTH held against bready=0).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   axi_slv_aw*               AW channel (valid/ready + id/addr/len/size/burst/user)
//   axi_slv_w*                W channel (valid/ready + data/strb/last)
//   axi_slv_b*                B channel (valid/ready + id/resp/user)
//   mem_wen/waddr/wdata/wstrb memory write port, one strobe per accepted legal beat

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_slv_wr_ctrl #(
    parameter int OST_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        axi_slv_awvalid,
    output logic                        axi_slv_awready,
    input  logic [`AXI_ID_W-1:0]        axi_slv_awid,
    input  logic [`AXI_ADDR_W-1:0]      axi_slv_awaddr,
    input  logic [`AXI_LEN_W-1:0]       axi_slv_awlen,
    input  logic [`AXI_SIZE_W-1:0]      axi_slv_awsize,
    input  logic [`AXI_BURST_W-1:0]     axi_slv_awburst,
    input  logic [`AXI_USER_W-1:0]      axi_slv_awuser,

    input  logic                        axi_slv_wvalid,
    output logic                        axi_slv_wready,
    input  logic [`AXI_DATA_W-1:0]      axi_slv_wdata,
    input  logic [`AXI_DATA_W/8-1:0]    axi_slv_wstrb,
    input  logic                        axi_slv_wlast,

    output logic                        axi_slv_bvalid,
    input  logic                        axi_slv_bready,
    output logic [`AXI_ID_W-1:0]        axi_slv_bid,
    output logic [`AXI_RESP_W-1:0]      axi_slv_bresp,
    output logic [`AXI_USER_W-1:0]      axi_slv_buser,

    output logic                        mem_wen,
    output logic [`AXI_ADDR_W-1:0]      mem_waddr,
    output logic [`AXI_DATA_W-1:0]      mem_wdata,
    output logic [`AXI_DATA_W/8-1:0]    mem_wstrb
);

    localparam int ADDR_W = `AXI_ADDR_W;
    localparam int PTR_W  = $clog2(OST_DEPTH);
    localparam logic [`AXI_SIZE_W-1:0]  MAX_SIZE   = `AXI_SIZE_W'($clog2(`AXI_DATA_W/8));
    localparam logic [`AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [`AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [`AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;
    localparam logic [`AXI_BURST_W-1:0] BURST_RSVD  = 2'b11;
    localparam logic [`AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
    localparam logic [`AXI_RESP_W-1:0]  RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [`AXI_ID_W-1:0]    id;
        logic [`AXI_ADDR_W-1:0]  addr;
        logic [`AXI_LEN_W-1:0]   len;
        logic [`AXI_SIZE_W-1:0]  size;
        logic [`AXI_BURST_W-1:0] burst;
        logic [`AXI_USER_W-1:0]  user;
    } aw_entry_t;

    typedef struct packed {
        logic [`AXI_ID_W-1:0]    id;
        logic [`AXI_RESP_W-1:0]  resp;
        logic [`AXI_USER_W-1:0]  user;
    } b_entry_t;

    aw_entry_t               aw_mem [OST_DEPTH];
    b_entry_t                b_mem  [OST_DEPTH];
    logic [PTR_W:0]          aw_wptr, aw_rptr;
    logic [PTR_W:0]          b_wptr, b_rptr;
    logic                    ready_en;

    logic [`AXI_LEN_W-1:0]   beat_cnt;
    logic                    err_flag;
    logic [ADDR_W-1:0]       cur_addr;

    logic                    aw_full, aw_not_empty;
    logic                    b_full, b_not_empty;
    logic                    aw_push, beat_fire, burst_end, b_pop;
    aw_entry_t               aw_in, head;
    b_entry_t                b_in, b_head;

    logic                    last_beat, wlast_err;
    logic                    bad_size, bad_burst, bad_wrap, illegal;
    logic [ADDR_W-1:0]       beat_addr, bytes, span, wrap_lo, incr_addr, next_addr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign aw_not_empty = (aw_wptr != aw_rptr);
    assign aw_full      = (aw_wptr[PTR_W] != aw_rptr[PTR_W]) &&
                          (aw_wptr[PTR_W-1:0] == aw_rptr[PTR_W-1:0]);
    assign b_not_empty  = (b_wptr != b_rptr);
    assign b_full       = (b_wptr[PTR_W] != b_rptr[PTR_W]) &&
                          (b_wptr[PTR_W-1:0] == b_rptr[PTR_W-1:0]);

    // ready_en keeps both ready outputs low until one cycle after reset release.
    assign axi_slv_awready = ready_en & ~aw_full;
    assign axi_slv_wready  = ready_en & aw_not_empty & ~b_full;
    assign axi_slv_bvalid  = b_not_empty;

    assign aw_push   = axi_slv_awvalid & axi_slv_awready;
    assign beat_fire = axi_slv_wvalid & axi_slv_wready;
    assign b_pop     = axi_slv_bvalid & axi_slv_bready;

    assign aw_in = '{id:    axi_slv_awid,
                     addr:  axi_slv_awaddr,
                     len:   axi_slv_awlen,
                     size:  axi_slv_awsize,
                     burst: axi_slv_awburst,
                     user:  axi_slv_awuser};

    assign head   = aw_mem[aw_rptr[PTR_W-1:0]];
    assign b_head = b_mem[b_rptr[PTR_W-1:0]];

    // Burst length comes from AWLEN only; wlast is merely checked against it.
    assign last_beat = (beat_cnt == head.len);
    assign wlast_err = (axi_slv_wlast != last_beat);
    assign burst_end = beat_fire & last_beat;

    assign bad_size  = (head.size > MAX_SIZE);
    assign bad_burst = (head.burst == BURST_RSVD);
    assign bad_wrap  = (head.burst == BURST_WRAP) &&
                       !((head.len == 8'd1) || (head.len == 8'd3) ||
                         (head.len == 8'd7) || (head.len == 8'd15));
    assign illegal   = bad_size | bad_burst | bad_wrap;

    // First beat takes the queued start address; later beats use the running one.
    assign beat_addr = (beat_cnt == '0) ? head.addr : cur_addr;
    assign bytes     = ADDR_W'(1) << head.size;
    assign span      = (ADDR_W'(head.len) + ADDR_W'(1)) << head.size;
    assign wrap_lo   = beat_addr & ~(span - ADDR_W'(1));
    assign incr_addr = beat_addr + bytes;

    always_comb begin
        next_addr = beat_addr;
        case (head.burst)
            BURST_FIXED: next_addr = beat_addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (incr_addr == wrap_lo + span) ? wrap_lo : incr_addr;
            default:     next_addr = beat_addr;
        endcase
    end

    assign b_in = '{id:   head.id,
                    resp: (err_flag | wlast_err | illegal) ? RESP_SLVERR : RESP_OKAY,
                    user: head.user};

    assign mem_wen   = beat_fire & ~illegal;
    assign mem_waddr = beat_addr;
    assign mem_wdata = axi_slv_wdata;
    assign mem_wstrb = axi_slv_wstrb;

    // Outputs read as zero while the response queue is empty.
    assign axi_slv_bid   = b_not_empty ? b_head.id   : '0;
    assign axi_slv_bresp = b_not_empty ? b_head.resp : '0;
    assign axi_slv_buser = b_not_empty ? b_head.user : '0;

    always_ff @(posedge clk) begin
        if (aw_push) begin
            aw_mem[aw_wptr[PTR_W-1:0]] <= aw_in;
        end
        if (burst_end) begin
            b_mem[b_wptr[PTR_W-1:0]] <= b_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
            aw_wptr  <= '0;
            aw_rptr  <= '0;
            b_wptr   <= '0;
            b_rptr   <= '0;
            beat_cnt <= '0;
            err_flag <= 1'b0;
            cur_addr <= '0;
        end else begin
            ready_en <= 1'b1;
            if (aw_push) begin
                aw_wptr <= aw_wptr + 1'b1;
            end
            if (b_pop) begin
                b_rptr <= b_rptr + 1'b1;
            end
            if (beat_fire) begin
                cur_addr <= next_addr;
                if (last_beat) begin
                    aw_rptr  <= aw_rptr + 1'b1;
                    b_wptr   <= b_wptr + 1'b1;
                    beat_cnt <= '0;
                    err_flag <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    err_flag <= err_flag | wlast_err;
                end
            end
        end
    end

endmodule
